// File: rtl/dram_bank_timing_bfm.sv
// rtl/dram_bank_timing_bfm.sv - command-driven DRAM bank/timing model with CAS read pipeline
// Optional refresh command enabled by DRAM_BFM_REFRESH_EN.
module dram_bank_timing_bfm #(
   parameter int NUM_OF_BANKS = 8,
   parameter int NUM_OF_ROWS  = 128,
   parameter int NUM_OF_COLS  = 8,
   parameter int DATA_WIDTH   = 8,
   parameter int T_RCD        = 3,
   parameter int CL           = 4,
   parameter int T_RFC        = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic [2:0]                      cmd,
   input  logic [$clog2(NUM_OF_BANKS)-1:0] bankid,
   input  logic [$clog2(NUM_OF_ROWS)-1:0]  rowid,
   input  logic [$clog2(NUM_OF_COLS)-1:0]  colid,
   input  logic [DATA_WIDTH-1:0]           din,
   output logic [DATA_WIDTH-1:0]           dout,
   output logic                            dout_valid,
   output logic                            err,
   output logic [1:0]                      err_code
);

   localparam int BW    = $clog2(NUM_OF_BANKS);
   localparam int RW    = $clog2(NUM_OF_ROWS);
   localparam int CW    = $clog2(NUM_OF_COLS);
   localparam int AW    = BW + RW + CW;
   localparam int DEPTH = NUM_OF_BANKS * NUM_OF_ROWS * NUM_OF_COLS;
   localparam int CNTW  = $clog2(T_RCD + 1);
   localparam int RFCW  = $clog2(T_RFC + 1);

   localparam logic [2:0] CMD_NOP = 3'b000;
   localparam logic [2:0] CMD_ACT = 3'b001;
   localparam logic [2:0] CMD_RD  = 3'b010;
   localparam logic [2:0] CMD_WR  = 3'b011;
   localparam logic [2:0] CMD_PRE = 3'b100;
   localparam logic [2:0] CMD_REF = 3'b101;

   localparam logic [1:0] ERR_NOT_OPEN = 2'b01;
   localparam logic [1:0] ERR_OPEN     = 2'b10;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

   typedef enum logic [1:0] {
      BANK_IDLE,
      BANK_ACTIVATING,
      BANK_ACTIVE
   } bank_state_e;

   bank_state_e           state_q [NUM_OF_BANKS];
   bank_state_e           state_d [NUM_OF_BANKS];
   logic [CNTW-1:0]       cnt_q   [NUM_OF_BANKS];
   logic [CNTW-1:0]       cnt_d   [NUM_OF_BANKS];
   logic [RW-1:0]         row_q   [NUM_OF_BANKS];
   logic [RW-1:0]         row_d   [NUM_OF_BANKS];

   logic [DATA_WIDTH-1:0] mem     [DEPTH];
   logic [AW-1:0]         addr;
   logic [DATA_WIDTH-1:0] rd_data;

   logic                  accept;
   logic                  bank_ready;
   logic                  rd_en;
   logic                  wr_en;
   logic                  err_d;
   logic [1:0]            code_d;
   logic                  ref_start;
   logic [RFCW-1:0]       ref_cnt_q;

   logic [CL-1:0]         pipe_v;
   logic [DATA_WIDTH-1:0] pipe_d  [CL];

`ifdef DRAM_BFM_REFRESH_EN
   logic                  all_idle;

   always_comb begin
      all_idle = 1'b1;
      for (int b = 0; b < NUM_OF_BANKS; b++) begin
         if (state_q[b] != BANK_IDLE) all_idle = 1'b0;
      end
   end
`endif

   assign cmd_ready  = (ref_cnt_q == '0);
   assign accept     = cmd_valid & cmd_ready;
   // An activating bank whose counter has drained is usable on this very edge.
   assign bank_ready = (state_q[bankid] == BANK_ACTIVE) ||
                       ((state_q[bankid] == BANK_ACTIVATING) && (cnt_q[bankid] == '0));
   assign addr       = {bankid, row_q[bankid], colid};
   assign rd_data    = mem[addr];

   always_comb begin
      for (int b = 0; b < NUM_OF_BANKS; b++) begin
         state_d[b] = state_q[b];
         cnt_d[b]   = cnt_q[b];
         row_d[b]   = row_q[b];
         if (state_q[b] == BANK_ACTIVATING) begin
            if (cnt_q[b] == '0) state_d[b] = BANK_ACTIVE;
            else                cnt_d[b]   = cnt_q[b] - CNTW'(1);
         end
      end
      rd_en     = 1'b0;
      wr_en     = 1'b0;
      err_d     = 1'b0;
      code_d    = err_code;
      ref_start = 1'b0;

      if (accept) begin
         case (cmd)
            CMD_NOP: ;
            CMD_ACT: begin
               if (state_q[bankid] == BANK_IDLE) begin
                  state_d[bankid] = BANK_ACTIVATING;
                  cnt_d[bankid]   = CNTW'(T_RCD - 1);
                  row_d[bankid]   = rowid;
               end else begin
                  err_d  = 1'b1;
                  code_d = ERR_OPEN;
               end
            end
            CMD_RD, CMD_WR: begin
               if (bank_ready) begin
                  rd_en = (cmd == CMD_RD);
                  wr_en = (cmd == CMD_WR);
               end else begin
                  err_d  = 1'b1;
                  code_d = ERR_NOT_OPEN;
               end
            end
            CMD_PRE: state_d[bankid] = BANK_IDLE;
`ifdef DRAM_BFM_REFRESH_EN
            CMD_REF: begin
               if (all_idle) begin
                  ref_start = 1'b1;
               end else begin
                  err_d  = 1'b1;
                  code_d = ERR_OPEN;
               end
            end
`endif
            default: begin
               err_d  = 1'b1;
               code_d = ERR_ILLEGAL;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < NUM_OF_BANKS; b++) begin
            state_q[b] <= BANK_IDLE;
            cnt_q[b]   <= '0;
            row_q[b]   <= '0;
         end
      end else begin
         for (int b = 0; b < NUM_OF_BANKS; b++) begin
            state_q[b] <= state_d[b];
            cnt_q[b]   <= cnt_d[b];
            row_q[b]   <= row_d[b];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[addr] <= din;
      end
   end

   // Without the refresh build ref_start never fires, so cmd_ready stays high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  ref_cnt_q <= '0;
      else if (ref_start)       ref_cnt_q <= RFCW'(T_RFC);
      else if (ref_cnt_q != '0) ref_cnt_q <= ref_cnt_q - RFCW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_v     <= '0;
         for (int i = 0; i < CL; i++) pipe_d[i] <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         err        <= 1'b0;
         err_code   <= '0;
      end else begin
         pipe_v[0] <= rd_en;
         pipe_d[0] <= rd_data;
         for (int i = 1; i < CL; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
         end
         dout_valid <= pipe_v[CL-1];
         if (pipe_v[CL-1]) dout <= pipe_d[CL-1];
         err      <= err_d;
         err_code <= code_d;
      end
   end

endmodule

// File: tb/tb_dram_bank_timing_bfm.sv
// tb/tb_dram_bank_timing_bfm.sv - directed and random checks of the DRAM bank timing model
module tb_dram_bank_timing_bfm;

   localparam int NB   = 8;
   localparam int NR   = 128;
   localparam int NC   = 8;
   localparam int DW   = 8;
   localparam int TRCD = 3;
   localparam int CLAT = 4;
   localparam int TRFC = 16;

   localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3,
                          C_PRE = 3'd4, C_REF = 3'd5;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [2:0]    cmd;
   logic [2:0]    bankid;
   logic [6:0]    rowid;
   logic [2:0]    colid;
   logic [DW-1:0] din;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          err;
   logic [1:0]    err_code;

   always #5 clk = ~clk;

   dram_bank_timing_bfm #(
      .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC), .DATA_WIDTH(DW),
      .T_RCD(TRCD), .CL(CLAT), .T_RFC(TRFC)
   ) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd(cmd), .bankid(bankid), .rowid(rowid), .colid(colid), .din(din),
      .dout(dout), .dout_valid(dout_valid), .err(err), .err_code(err_code)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: open rows, activation times, reads due at absolute cycles.
   logic [DW-1:0] m_mem [NB][NR][NC];
   bit            m_open [NB];
   int            m_row [NB];
   int            m_act [NB];
   int            m_ref_until;
   typedef struct {int due; logic [DW-1:0] data;} rd_t;
   rd_t           rq [$];

   logic          exp_valid, exp_err, exp_ready;
   logic [DW-1:0] exp_dout;
   logic [1:0]    exp_code;

   function automatic void check(string name, int act, int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endfunction

   function automatic void model_reset();
      for (int b = 0; b < NB; b++) begin
         m_open[b] = 0;
         m_row[b]  = 0;
         m_act[b]  = 0;
         for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) m_mem[b][r][c] = '0;
      end
      rq.delete();
      m_ref_until = 0;
      exp_valid = 0; exp_err = 0; exp_ready = 1; exp_dout = '0; exp_code = '0;
   endfunction

   function automatic bit m_legal(int b);
      return m_open[b] && (cyc >= m_act[b] + TRCD);
   endfunction

   function automatic void m_flag(logic [1:0] code);
      exp_err  = 1;
      exp_code = code;
   endfunction

   function automatic void model_edge();
      int b;
      b = int'(bankid);
      exp_err = 0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         exp_valid = 1;
         exp_dout  = rq[0].data;
         void'(rq.pop_front());
      end else begin
         exp_valid = 0;
      end
      if (cmd_valid && exp_ready) begin
         case (cmd)
            C_NOP: ;
            C_ACT: if (m_open[b]) m_flag(2'b10);
                   else begin m_open[b] = 1; m_row[b] = int'(rowid); m_act[b] = cyc; end
            C_RD:  if (m_legal(b)) rq.push_back('{cyc + CLAT, m_mem[b][m_row[b]][colid]});
                   else m_flag(2'b01);
            C_WR:  if (m_legal(b)) m_mem[b][m_row[b]][colid] = din;
                   else m_flag(2'b01);
            C_PRE: m_open[b] = 0;
`ifdef DRAM_BFM_REFRESH_EN
            C_REF: begin
               bit any_open;
               any_open = 0;
               for (int i = 0; i < NB; i++) any_open |= m_open[i];
               if (any_open) m_flag(2'b10);
               else m_ref_until = cyc + TRFC;
            end
`endif
            default: m_flag(2'b11);
         endcase
      end
`ifdef DRAM_BFM_REFRESH_EN
      exp_ready = (cyc >= m_ref_until);
`else
      exp_ready = 1;
`endif
   endfunction

   function automatic void compare_all();
      check("dout_valid", int'(dout_valid), int'(exp_valid));
      check("dout", int'(dout), int'(exp_dout));
      check("err", int'(err), int'(exp_err));
      check("err_code", int'(err_code), int'(exp_code));
      check("cmd_ready", int'(cmd_ready), int'(exp_ready));
   endfunction

   task automatic step();
      @(posedge clk);
      cyc++;
      if (rst) model_reset();
      else     model_edge();
      #1;
      compare_all();
      @(negedge clk);
   endtask

   task automatic issue(input logic [2:0] c, input int b, input int r, input int col, input int d);
      cmd_valid = 1'b1;
      cmd       = c;
      bankid    = 3'(b);
      rowid     = 7'(r);
      colid     = 3'(col);
      din       = 8'(d);
      step();
      cmd_valid = 1'b0;
      cmd       = C_NOP;
   endtask

   task automatic idle(input int n);
      cmd_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("async_rst_valid", int'(dout_valid), 0);
      check("async_rst_dout", int'(dout), 0);
      check("async_rst_ready", int'(cmd_ready), 1);
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      int low_cnt;
      rst = 1'b1; cmd_valid = 1'b0; cmd = C_NOP;
      bankid = '0; rowid = '0; colid = '0; din = '0;
      model_reset();
      step();
      step();
      check("reset_ready", int'(cmd_ready), 1);
      check("reset_err_code", int'(err_code), 0);
      rst = 1'b0;
      idle(2);

      // basic write/read with CL latency
      issue(C_ACT, 2, 5, 0, 0);
      idle(TRCD - 1);
      issue(C_WR, 2, 0, 1, 8'hA5);
      issue(C_RD, 2, 0, 1, 0);
      idle(CLAT - 1);
      check("t1_early_valid", int'(dout_valid), 0);
      idle(1);
      check("t1_valid", int'(dout_valid), 1);
      check("t1_data", int'(dout), 8'hA5);
      check("t1_no_err", int'(err), 0);

      // RD during T_RCD
      issue(C_ACT, 0, 3, 0, 0);
      issue(C_RD, 0, 0, 0, 0);
      check("t2_err", int'(err), 1);
      check("t2_code", int'(err_code), 1);
      idle(1);
      issue(C_RD, 0, 0, 0, 0);
      check("t2_legal_rd", int'(err), 0);
      idle(CLAT);

      // double ACT, re-open, row isolation
      issue(C_ACT, 1, 0, 0, 0);
      idle(TRCD - 1);
      issue(C_ACT, 1, 7, 0, 0);
      check("t3_code", int'(err_code), 2);
      issue(C_PRE, 1, 0, 0, 0);
      issue(C_ACT, 1, 7, 0, 0);
      idle(TRCD - 1);
      issue(C_WR, 1, 0, 0, 8'h3C);
      issue(C_RD, 1, 0, 0, 0);
      idle(CLAT);
      check("t3_data", int'(dout), 8'h3C);
      issue(C_PRE, 1, 0, 0, 0);
      issue(C_ACT, 1, 0, 0, 0);
      idle(TRCD - 1);
      issue(C_RD, 1, 0, 0, 0);
      idle(CLAT);
      check("t3_row0_valid", int'(dout_valid), 1);
      check("t3_row0_data", int'(dout), 0);

      // back-to-back reads
      issue(C_ACT, 3, 9, 0, 0);
      idle(TRCD - 1);
      for (int k = 0; k < 4; k++) issue(C_WR, 3, 0, k, 8'h10 + k);
      for (int k = 0; k < 4; k++) issue(C_RD, 3, 0, k, 0);
      for (int k = 0; k < 4; k++) begin
         idle(1);
         check("t4_beat_valid", int'(dout_valid), 1);
         check("t4_beat_data", int'(dout), 8'h10 + k);
      end

      // reset with a read in flight
      issue(C_ACT, 5, 2, 0, 0);
      idle(TRCD - 1);
      issue(C_WR, 5, 0, 2, 8'h77);
      issue(C_RD, 5, 0, 2, 0);
      idle(2);
      do_reset();
      low_cnt = 0;
      for (int k = 0; k < CLAT + 2; k++) begin
         idle(1);
         if (dout_valid) low_cnt++;
      end
      check("t5_no_valid", low_cnt, 0);
      issue(C_ACT, 5, 2, 0, 0);
      idle(TRCD - 1);
      issue(C_RD, 5, 0, 2, 0);
      idle(CLAT);
      check("t5_valid", int'(dout_valid), 1);
      check("t5_cleared", int'(dout), 0);
      issue(C_PRE, 5, 0, 0, 0);

      // refresh
`ifdef DRAM_BFM_REFRESH_EN
      issue(C_REF, 0, 0, 0, 0);
      low_cnt = (cmd_ready == 1'b0) ? 1 : 0;
      for (int k = 0; k < TRFC + 4; k++) begin
         idle(1);
         if (!cmd_ready) low_cnt++;
      end
      check("t6_ready_low_cycles", low_cnt, TRFC);
      issue(C_ACT, 4, 1, 0, 0);
      idle(TRCD - 1);
      issue(C_REF, 0, 0, 0, 0);
      check("t6_ref_busy_code", int'(err_code), 2);
      issue(C_PRE, 4, 0, 0, 0);
`else
      issue(C_REF, 0, 0, 0, 0);
      check("t6_ref_err", int'(err), 1);
      check("t6_ref_code", int'(err_code), 3);
`endif

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int r;
         if (i == 1500) do_reset();
         if (i % 500 == 499) begin
            for (int b = 0; b < NB; b++) issue(C_PRE, b, 0, 0, 0);
            issue(C_REF, 0, 0, 0, 0);
         end
         r = $urandom_range(0, 15);
         cmd_valid = ($urandom_range(0, 9) != 0);
         if (r < 4)       cmd = C_ACT;
         else if (r < 8)  cmd = C_RD;
         else if (r < 10) cmd = C_WR;
         else if (r < 12) cmd = C_PRE;
         else if (r == 12) cmd = C_NOP;
         else if (r == 13) cmd = C_REF;
         else             cmd = 3'(6 + (r & 1));
         bankid = 3'($urandom_range(0, NB - 1));
         rowid  = 7'($urandom_range(0, 3));
         colid  = 3'($urandom_range(0, NC - 1));
         din    = 8'($urandom_range(0, 255));
         step();
      end
      idle(CLAT + 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dram_bank_timing_bfm.md
Name: dram_bank_timing_bfm

Overview:
- Next-generation DRAM behavioural model for the controller testbench. Command-driven, not a flat memory.
- Parametrised bank, row, column and data geometry. Tracks an open row per bank, enforces activate-to-access delay (T_RCD) and returns read data after CAS latency (CL) through a valid-qualified pipeline.
- Flags protocol violations so controller benches can self-check.

Parameters:
- NUM_OF_BANKS, 8, number of banks (power of 2, >=2)
- NUM_OF_ROWS, 128, rows per bank (power of 2)
- NUM_OF_COLS, 8, columns per row (power of 2)
- DATA_WIDTH, 8, bits per column word
- T_RCD, 3, cycles from accepted ACT until RD/WR to that bank is legal (>=1)
- CL, 4, cycles from accepted RD to dout_valid (>=1)
- T_RFC, 16, refresh busy cycles (optional feature only)

Ports:
- clk  in  1  clock; all activity on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present this cycle
- cmd_ready  out  1  model accepts command; a command is accepted when cmd_valid & cmd_ready
- cmd  in  3  000 NOP, 001 ACT, 010 RD, 011 WR, 100 PRE, 101 REF (optional), others illegal
- bankid  in  $clog2(NUM_OF_BANKS)  target bank
- rowid  in  $clog2(NUM_OF_ROWS)  row for ACT; ignored for other commands
- colid  in  $clog2(NUM_OF_COLS)  column for RD/WR
- din  in  DATA_WIDTH  write data, sampled with an accepted WR
- dout  out  DATA_WIDTH  read data
- dout_valid  out  1  dout is valid this cycle
- err  out  1  one-cycle pulse on an illegal accepted command
- err_code  out  2  01 bank not open, 10 bank already open or activating, 11 illegal or unsupported command; holds its last value between pulses

Behaviour:
- Reset (async assert, sync use on the first edge after deassert):
  - dout=0, dout_valid=0, err=0, err_code=0, cmd_ready=1.
  - All banks IDLE; all T_RCD counters and the CL pipeline cleared.
  - Entire storage array zeroed.
  - Reset mid-operation discards in-flight reads; no dout_valid pulse is produced for them.
- Per-bank state machine:
  - IDLE -ACT-> ACTIVATING. open_row<=rowid; counter loaded with T_RCD-1.
  - ACTIVATING: counter decrements each cycle. Moves to ACTIVE when the counter is 0. RD/WR become legal exactly T_RCD cycles after the ACT edge.
  - ACTIVE -PRE-> IDLE, effective the next cycle.
  - PRE to an IDLE bank is a legal no-op. PRE to an ACTIVATING bank aborts the activation and returns the bank to IDLE.
- RD to an ACTIVE bank:
  - Reads storage[bankid][open_row][colid].
  - dout/dout_valid appear exactly CL cycles after the accept edge.
  - The pipeline accepts one RD per cycle; back-to-back RDs give back-to-back valid beats.
  - dout holds its last value when dout_valid=0.
- WR to an ACTIVE bank: writes din at the accept edge. A RD to the same address on the next cycle returns the new data.
- Illegal accepted commands have no state or storage effect. err pulses on the cycle after the accept edge with err_code set:
  - RD/WR to an IDLE or ACTIVATING bank: code 01.
  - ACT to an ACTIVATING or ACTIVE bank: code 10.
  - Undefined cmd encodings: code 11.
- NOP and cmd_valid=0 have no effect. Banks are fully independent, and commands to other banks do not disturb a bank's counter.
- cmd_ready is constant 1 unless the optional feature is enabled.

Optional Feature:
- Macro DRAM_BFM_REFRESH_EN.
- Defined:
  - cmd 101 REF is legal only when all banks are IDLE. Otherwise it is flagged with err_code 10 and ignored.
  - An accepted legal REF drops cmd_ready for T_RFC cycles starting the next cycle. Storage is retained.
  - A REF counter is cleared on reset.
- Undefined: 101 is an undefined encoding, flagged with err_code 11. cmd_ready is tied to 1.

Test Plan:
- ACT b2 r5, wait T_RCD=3, WR b2 c1 din=0xA5, RD b2 c1 -> dout=0xA5 with dout_valid high exactly 4 cycles after the RD accept; no err.
- ACT b0, RD b0 on the next cycle (during T_RCD) -> err pulse, err_code=01, no dout_valid; RD at cycle +3 -> legal.
- ACT b1 r0, then ACT b1 r7 -> err_code=10, open row stays 0; PRE b1, ACT b1 r7, WR c0 0x3C, RD c0 -> 0x3C; the row 0 word is unchanged.
- 4 back-to-back RDs to b3 c0..c3 (preloaded 0x10..0x13) -> 4 consecutive dout_valid beats 0x10..0x13 starting at CL.
- Assert rst 2 cycles after an RD accept -> dout_valid never pulses, dout=0; a subsequent RD of the previously written address returns 0.
- With DRAM_BFM_REFRESH_EN: all banks IDLE, REF -> cmd_ready low for 16 cycles; REF with b4 ACTIVE -> err_code=10. Without the macro, REF -> err_code=11.
